map_grid_server: RTL and testbench

- Responder side of the grid-lookup interface. Owns the level map: GRID_W x GRID_H cells, CELL_BITS-bit cell type, 0 = empty.
- Answers (grid_x, grid_y) -> grid_out lookups from two requesters: port A (player movement/collision) and port B (raycaster).
- Has a single-cell write port for map edits (doors, pickups).
- After reset, fills the map by itself: a wall on the border, empty inside.

---
 rtl/map_grid_if.sv | 34 +++
 rtl/map_grid_server.sv | 173 +++++++++++++++++
 tb/tb_map_grid_server.sv | 255 +++++++++++++++++++++++++
 3 files changed

// File: rtl/map_grid_if.sv
// Grid-lookup bus between the requesters (master) and map_grid_server (slave).
// Handshake: req with x/y held until a one-cycle ack; a write is accepted on any edge where wr_en && wr_ready.
interface map_grid_if #(
  parameter int CELL_BITS = 3
);
  logic                 a_req;
  logic [5:0]           a_grid_x;
  logic [4:0]           a_grid_y;
  logic                 a_ack;
  logic [CELL_BITS-1:0] a_grid_out;
  logic                 b_req;
  logic [5:0]           b_grid_x;
  logic [4:0]           b_grid_y;
  logic                 b_ack;
  logic [CELL_BITS-1:0] b_grid_out;
  logic                 wr_en;
  logic [5:0]           wr_grid_x;
  logic [4:0]           wr_grid_y;
  logic [CELL_BITS-1:0] wr_data;
  logic                 wr_ready;
  logic                 init_done;

  modport master (
    output a_req, a_grid_x, a_grid_y, b_req, b_grid_x, b_grid_y,
           wr_en, wr_grid_x, wr_grid_y, wr_data,
    input  a_ack, a_grid_out, b_ack, b_grid_out, wr_ready, init_done
  );

  modport slave (
    input  a_req, a_grid_x, a_grid_y, b_req, b_grid_x, b_grid_y,
           wr_en, wr_grid_x, wr_grid_y, wr_data,
    output a_ack, a_grid_out, b_ack, b_grid_out, wr_ready, init_done
  );
endinterface

// File: rtl/map_grid_server.sv
// Level-map server: self-initialising cell array with two arbitrated lookup ports.
// Optional single-cell write port enabled by defining MAP_WRITE_PORT_EN.
module map_grid_server #(
  parameter int                   GRID_W      = 64,
  parameter int                   GRID_H      = 32,
  parameter int                   CELL_BITS   = 3,
  parameter logic [CELL_BITS-1:0] BORDER_CELL = CELL_BITS'(1)
) (
  input  logic       clock,
  input  logic       resetn,
  map_grid_if.slave  bus,
  output logic [1:0] dbg_state_o
);
  localparam int DEPTH = GRID_W * GRID_H;
  localparam int AW    = $clog2(DEPTH);
  localparam logic [5:0] LAST_X = 6'(GRID_W - 1);
  localparam logic [4:0] LAST_Y = 5'(GRID_H - 1);

  typedef enum logic [1:0] {ST_INIT, ST_IDLE, ST_READ, ST_RESP} state_t;

  state_t               state_q, state_d;
  logic [5:0]           init_x_q, init_x_d;
  logic [4:0]           init_y_q, init_y_d;
  logic                 last_b_q, last_b_d;   // 1: most recent grant went to port B
  logic                 grant_b_q, grant_b_d;
  logic [AW-1:0]        addr_q, addr_d;
  logic                 oor_q, oor_d;
  logic                 a_ack_q, a_ack_d, b_ack_q, b_ack_d;
  logic [CELL_BITS-1:0] a_out_q, a_out_d, b_out_q, b_out_d;
  logic                 init_done_q, init_done_d;
  logic [CELL_BITS-1:0] rd_data_q;
  logic [CELL_BITS-1:0] mem [DEPTH];

  logic                 mem_we;
  logic [AW-1:0]        mem_waddr;
  logic [CELL_BITS-1:0] mem_wdata;
  logic                 wr_ready_w;
  logic                 read_grant;
  logic                 pick_b;
  logic [5:0]           gx;
  logic [4:0]           gy;

  function automatic logic in_range(input logic [5:0] x, input logic [4:0] y);
    return ({1'b0, x} < 7'(GRID_W)) && ({1'b0, y} < 6'(GRID_H));
  endfunction

  function automatic logic [AW-1:0] cell_addr(input logic [5:0] x, input logic [4:0] y);
    return AW'(y) * AW'(GRID_W) + AW'(x);
  endfunction

`ifndef MAP_WRITE_PORT_EN
  logic unused_wr;
  assign unused_wr = ^{bus.wr_en, bus.wr_grid_x, bus.wr_grid_y, bus.wr_data};
`endif

  // With both ports requesting, the port that did not win last time goes next.
  assign pick_b = bus.b_req && (!bus.a_req || !last_b_q);
  assign gx     = pick_b ? bus.b_grid_x : bus.a_grid_x;
  assign gy     = pick_b ? bus.b_grid_y : bus.a_grid_y;

  always_comb begin
    state_d     = state_q;
    init_x_d    = init_x_q;
    init_y_d    = init_y_q;
    last_b_d    = last_b_q;
    grant_b_d   = grant_b_q;
    addr_d      = addr_q;
    oor_d       = oor_q;
    a_ack_d     = 1'b0;
    b_ack_d     = 1'b0;
    a_out_d     = a_out_q;
    b_out_d     = b_out_q;
    init_done_d = init_done_q;
    mem_we      = 1'b0;
    mem_waddr   = cell_addr(init_x_q, init_y_q);
    mem_wdata   = '0;
    wr_ready_w  = 1'b0;
    read_grant  = 1'b0;
    case (state_q)
      ST_INIT: begin
        mem_we = 1'b1;
        if (init_x_q == 6'd0 || init_x_q == LAST_X || init_y_q == 5'd0 || init_y_q == LAST_Y)
          mem_wdata = BORDER_CELL;
        if (init_x_q == LAST_X) begin
          init_x_d = '0;
          if (init_y_q == LAST_Y) begin
            init_y_d    = '0;
            init_done_d = 1'b1;
            state_d     = ST_IDLE;
          end else begin
            init_y_d = init_y_q + 5'd1;
          end
        end else begin
          init_x_d = init_x_q + 6'd1;
        end
      end
      ST_IDLE: begin
`ifdef MAP_WRITE_PORT_EN
        wr_ready_w = 1'b1;
        if (bus.wr_en) begin
          mem_we    = in_range(bus.wr_grid_x, bus.wr_grid_y);
          mem_waddr = cell_addr(bus.wr_grid_x, bus.wr_grid_y);
          mem_wdata = bus.wr_data;
        end else begin
          read_grant = bus.a_req || bus.b_req;
        end
`else
        read_grant = bus.a_req || bus.b_req;
`endif
        if (read_grant) begin
          grant_b_d = pick_b;
          last_b_d  = pick_b;
          oor_d     = !in_range(gx, gy);
          addr_d    = in_range(gx, gy) ? cell_addr(gx, gy) : '0;
          state_d   = ST_READ;
        end
      end
      ST_READ: state_d = ST_RESP;
      ST_RESP: begin
        a_ack_d = !grant_b_q;
        b_ack_d = grant_b_q;
        if (grant_b_q) b_out_d = rd_data_q;
        else           a_out_d = rd_data_q;
        state_d = ST_IDLE;
      end
      default: state_d = ST_INIT;
    endcase
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_q     <= ST_INIT;
      init_x_q    <= '0;
      init_y_q    <= '0;
      last_b_q    <= 1'b1;
      grant_b_q   <= 1'b0;
      addr_q      <= '0;
      oor_q       <= 1'b0;
      a_ack_q     <= 1'b0;
      b_ack_q     <= 1'b0;
      a_out_q     <= '0;
      b_out_q     <= '0;
      init_done_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      init_x_q    <= init_x_d;
      init_y_q    <= init_y_d;
      last_b_q    <= last_b_d;
      grant_b_q   <= grant_b_d;
      addr_q      <= addr_d;
      oor_q       <= oor_d;
      a_ack_q     <= a_ack_d;
      b_ack_q     <= b_ack_d;
      a_out_q     <= a_out_d;
      b_out_q     <= b_out_d;
      init_done_q <= init_done_d;
    end
  end

  // Storage is fully rewritten by the init sweep, so it carries no reset.
  always_ff @(posedge clock) begin
    if (mem_we) mem[mem_waddr] <= mem_wdata;
    if (state_q == ST_READ) rd_data_q <= oor_q ? BORDER_CELL : mem[addr_q];
  end

  assign bus.a_ack      = a_ack_q;
  assign bus.b_ack      = b_ack_q;
  assign bus.a_grid_out = a_out_q;
  assign bus.b_grid_out = b_out_q;
  assign bus.init_done  = init_done_q;
  assign bus.wr_ready   = wr_ready_w;
  assign dbg_state_o    = state_q;
endmodule

// File: tb/tb_map_grid_server.sv
// Self-checking bench for map_grid_server: a 64x32 instance plus a 40x32 instance for out-of-range cases.
module tb_map_grid_server;
`ifdef MAP_WRITE_PORT_EN
  localparam bit WR_EN = 1'b1;
`else
  localparam bit WR_EN = 1'b0;
`endif

  logic       clock;
  logic       resetn;
  logic [1:0] dbg_state;
  logic [1:0] dbg_state40;

  map_grid_if #(.CELL_BITS(3)) bus ();
  map_grid_if #(.CELL_BITS(3)) bus40 ();

  map_grid_server #(.GRID_W(64), .GRID_H(32), .CELL_BITS(3), .BORDER_CELL(3'b001)) dut (
    .clock(clock), .resetn(resetn), .bus(bus), .dbg_state_o(dbg_state)
  );

  map_grid_server #(.GRID_W(40), .GRID_H(32), .CELL_BITS(3), .BORDER_CELL(3'b001)) dut40 (
    .clock(clock), .resetn(resetn), .bus(bus40), .dbg_state_o(dbg_state40)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int n_pass = 0;
  int n_total = 0;
  logic [2:0] model [64][32];
  logic [2:0] exp_q[$];

  typedef struct {
    bit         pb;
    logic [5:0] x;
    logic [4:0] y;
    logic [2:0] exp;
  } vec_t;
  vec_t vecs[8];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  task automatic model_reset();
    for (int x = 0; x < 64; x++)
      for (int y = 0; y < 32; y++)
        model[x][y] = (x == 0 || x == 63 || y == 0 || y == 31) ? 3'b001 : 3'b000;
  endtask

  task automatic wait_init(output int cnt, output bit saw_ack);
    cnt = 0;
    saw_ack = 1'b0;
    while (!bus.init_done && cnt < 3000) begin
      @(posedge clock); #1;
      cnt++;
      if (bus.a_ack || bus.b_ack) saw_ack = 1'b1;
    end
    bus.a_req = 1'b0;
    bus.b_req = 1'b0;
  endtask

  // One lookup, optionally with a write presented in the same cycle.
  task automatic lookup(input bit pb, input logic [5:0] x, input logic [4:0] y,
                        input bit do_wr, input logic [5:0] wx, input logic [4:0] wy,
                        input logic [2:0] wd, output logic [2:0] val);
    int lat;
    bit got;
    bit other;
    if (pb) begin bus.b_req = 1'b1; bus.b_grid_x = x; bus.b_grid_y = y; end
    else    begin bus.a_req = 1'b1; bus.a_grid_x = x; bus.a_grid_y = y; end
    bus.wr_en = do_wr; bus.wr_grid_x = wx; bus.wr_grid_y = wy; bus.wr_data = wd;
    lat = 0; got = 1'b0; other = 1'b0;
    while (!got && lat < 20) begin
      @(posedge clock); #1;
      lat++;
      bus.wr_en = 1'b0;
      if (pb ? bus.a_ack : bus.b_ack) other = 1'b1;
      if (pb ? bus.b_ack : bus.a_ack) got = 1'b1;
    end
    bus.a_req = 1'b0;
    bus.b_req = 1'b0;
    val = pb ? bus.b_grid_out : bus.a_grid_out;
    check("ack_seen", got, 1);
    check("latency", lat, (do_wr && WR_EN) ? 4 : 3);
    check("other_ack", other, 0);
    @(posedge clock); #1;
    check("ack_width", pb ? bus.b_ack : bus.a_ack, 0);
  endtask

  task automatic do_write(input logic [5:0] x, input logic [4:0] y, input logic [2:0] d);
    bus.wr_en = 1'b1; bus.wr_grid_x = x; bus.wr_grid_y = y; bus.wr_data = d;
    check("wr_ready", bus.wr_ready, WR_EN);
    @(posedge clock); #1;
    bus.wr_en = 1'b0;
    if (WR_EN) model[x][y] = d;
  endtask

  task automatic lookup40(input logic [5:0] x, input logic [4:0] y, input logic [2:0] exp, input string name);
    int lat;
    bus40.a_req = 1'b1; bus40.a_grid_x = x; bus40.a_grid_y = y;
    lat = 0;
    while (!bus40.a_ack && lat < 20) begin
      @(posedge clock); #1;
      lat++;
    end
    bus40.a_req = 1'b0;
    check({name, "_lat"}, lat, 3);
    check(name, bus40.a_grid_out, exp);
    @(posedge clock); #1;
  endtask

  initial begin
    int cnt;
    bit saw;
    logic [2:0] val;
    int order_q[$];
    int cyc_q[$];
    int cyc;
    bit both, wide, prev_any;
    bit pb, dw;
    logic [5:0] x, wx;
    logic [4:0] y, wy;
    logic [2:0] wd;

    vecs[0] = '{1'b0, 6'd10, 5'd5,  3'b000};
    vecs[1] = '{1'b0, 6'd0,  5'd3,  3'b001};
    vecs[2] = '{1'b0, 6'd63, 5'd31, 3'b001};
    vecs[3] = '{1'b1, 6'd1,  5'd1,  3'b000};
    vecs[4] = '{1'b1, 6'd62, 5'd30, 3'b000};
    vecs[5] = '{1'b0, 6'd63, 5'd0,  3'b001};
    vecs[6] = '{1'b1, 6'd0,  5'd31, 3'b001};
    vecs[7] = '{1'b1, 6'd32, 5'd16, 3'b000};

    resetn = 1'b0;
    bus.a_req = 1'b1; bus.a_grid_x = 6'd10; bus.a_grid_y = 5'd5;
    bus.b_req = 1'b0; bus.b_grid_x = '0; bus.b_grid_y = '0;
    bus.wr_en = 1'b0; bus.wr_grid_x = '0; bus.wr_grid_y = '0; bus.wr_data = '0;
    bus40.a_req = 1'b0; bus40.a_grid_x = '0; bus40.a_grid_y = '0;
    bus40.b_req = 1'b0; bus40.b_grid_x = '0; bus40.b_grid_y = '0;
    bus40.wr_en = 1'b0; bus40.wr_grid_x = '0; bus40.wr_grid_y = '0; bus40.wr_data = '0;
    model_reset();

    repeat (3) @(posedge clock);
    #1;
    check("rst_a_ack", bus.a_ack, 0);
    check("rst_b_ack", bus.b_ack, 0);
    check("rst_a_out", bus.a_grid_out, 0);
    check("rst_b_out", bus.b_grid_out, 0);
    check("rst_init_done", bus.init_done, 0);
    check("rst_wr_ready", bus.wr_ready, 0);
    check("rst_state", dbg_state, 0);

    resetn = 1'b1;
    wait_init(cnt, saw);
    check("init_clocks", cnt, 2048);
    check("init_no_ack", saw, 0);
    check("idle_state", dbg_state, 1);
    check("idle_wr_ready", bus.wr_ready, WR_EN);
    check("init40_done", bus40.init_done, 1);

    // Both ports requesting from reset: strict alternation starting with A.
    bus.a_req = 1'b1; bus.a_grid_x = 6'd0; bus.a_grid_y = 5'd0;
    bus.b_req = 1'b1; bus.b_grid_x = 6'd5; bus.b_grid_y = 5'd5;
    cyc = 0; both = 1'b0; wide = 1'b0; prev_any = 1'b0;
    while (order_q.size() < 4 && cyc < 60) begin
      @(posedge clock); #1;
      cyc++;
      if (bus.a_ack && bus.b_ack) both = 1'b1;
      if ((bus.a_ack || bus.b_ack) && prev_any) wide = 1'b1;
      prev_any = bus.a_ack || bus.b_ack;
      if (bus.a_ack || bus.b_ack) cyc_q.push_back(cyc);
      if (bus.a_ack) begin order_q.push_back(0); check("arb_a_data", bus.a_grid_out, 3'b001); end
      if (bus.b_ack) begin order_q.push_back(1); check("arb_b_data", bus.b_grid_out, 3'b000); end
    end
    bus.a_req = 1'b0;
    bus.b_req = 1'b0;
    check("arb_count", order_q.size(), 4);
    for (int i = 0; i < 4; i++)
      check("arb_order", (order_q.size() > i) ? order_q[i] : 9, i % 2);
    check("arb_first_ack", (cyc_q.size() > 0) ? cyc_q[0] : 0, 3);
    for (int i = 0; i < 3; i++)
      check("arb_spacing", (cyc_q.size() > i + 1) ? cyc_q[i+1] - cyc_q[i] : 0, 3);
    check("arb_both_high", both, 0);
    check("arb_ack_wide", wide, 0);
    @(posedge clock); #1;

    for (int i = 0; i < 8; i++) begin
      lookup(vecs[i].pb, vecs[i].x, vecs[i].y, 1'b0, '0, '0, '0, val);
      check($sformatf("vec%0d", i), val, vecs[i].exp);
    end

    // Write and read of the same cell presented together.
    if (WR_EN) model[10][5] = 3'b010;
    lookup(1'b0, 6'd10, 5'd5, 1'b1, 6'd10, 5'd5, 3'b010, val);
    check("wr_then_rd", val, WR_EN ? 3'b010 : 3'b000);

    for (int i = 0; i < 150; i++) begin
      if ($urandom_range(0, 4) == 0)
        do_write(6'($urandom_range(0, 63)), 5'($urandom_range(0, 31)), 3'($urandom_range(0, 7)));
      pb = 1'($urandom_range(0, 1));
      x  = 6'($urandom_range(0, 63));
      y  = 5'($urandom_range(0, 31));
      dw = ($urandom_range(0, 2) == 0);
      wx = $urandom_range(0, 1) ? x : 6'($urandom_range(0, 63));
      wy = $urandom_range(0, 1) ? y : 5'($urandom_range(0, 31));
      wd = 3'($urandom_range(0, 7));
      if (dw && WR_EN) model[wx][wy] = wd;
      exp_q.push_back(model[x][y]);
      lookup(pb, x, y, dw, wx, wy, wd, val);
      check("rand_lookup", val, exp_q.pop_front());
    end

    // Reset in the middle of a lookup.
    do_write(6'd10, 5'd5, 3'b110);
    lookup(1'b0, 6'd10, 5'd5, 1'b0, '0, '0, '0, val);
    check("pre_reset_cell", val, model[10][5]);
    bus.a_req = 1'b1; bus.a_grid_x = 6'd10; bus.a_grid_y = 5'd5;
    @(posedge clock); #1;
    check("mid_read_state", dbg_state, 2);
    resetn = 1'b0;
    #1;
    check("mid_rst_init_done", bus.init_done, 0);
    check("mid_rst_state", dbg_state, 0);
    model_reset();
    saw = 1'b0;
    repeat (3) begin
      @(posedge clock); #1;
      if (bus.a_ack) saw = 1'b1;
    end
    check("mid_rst_no_ack", saw, 0);
    resetn = 1'b1;
    wait_init(cnt, saw);
    check("reinit_clocks", cnt, 2048);
    check("reinit_no_ack", saw, 0);
    lookup(1'b0, 6'd10, 5'd5, 1'b0, '0, '0, '0, val);
    check("post_reset_cell", val, 3'b000);

    // Narrow map: x beyond the width is out of range.
    lookup40(6'd45, 5'd3, 3'b001, "w40_oor");
    lookup40(6'd39, 5'd3, 3'b001, "w40_right_wall");
    lookup40(6'd38, 5'd3, 3'b000, "w40_inside");
    bus40.wr_en = 1'b1; bus40.wr_grid_x = 6'd45; bus40.wr_grid_y = 5'd3; bus40.wr_data = 3'b010;
    @(posedge clock); #1;
    bus40.wr_en = 1'b0;
    lookup40(6'd5, 5'd4, 3'b000, "w40_no_alias");
    lookup40(6'd45, 5'd3, 3'b001, "w40_oor_after_wr");
    check("w40_state", dbg_state40, 1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
